// File: rtl/schmidl_cox_pkg.sv
// Shared types for the Schmidl-Cox transmit preamble inserter.
package schmidl_cox_pkg;

  localparam int unsigned SC_ITEM_W = 32;

  typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, GUARD} sc_tx_state_t;

  typedef logic [SC_ITEM_W-1:0] sample_t;

  localparam sample_t SC_ZERO_SAMPLE = '0;

endpackage

// File: rtl/schmidl_cox_preamble_rom.sv
// Preamble half-symbol table: single write port, registered read port with write-first bypass.
module schmidl_cox_preamble_rom #(
  parameter int unsigned ITEM_W   = 32,
  parameter int unsigned HALF_LEN = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  input  logic [$clog2(HALF_LEN)-1:0] wr_addr,
  input  logic [ITEM_W-1:0]           wr_data,
  input  logic [$clog2(HALF_LEN)-1:0] rd_addr,
  output logic [ITEM_W-1:0]           rd_data
);

  logic [ITEM_W-1:0] mem [HALF_LEN];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Write-first so a table write in the frame-start cycle is seen by the first read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           rd_data <= '0;
    else if (wr_en && wr_addr == rd_addr) rd_data <= wr_data;
    else                                  rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/schmidl_cox_preamble_inserter.sv
// Prefixes each TX frame with a twice-repeated Schmidl-Cox half-symbol from a writable table.
// Optional zero guard interval after each frame when SC_TX_GUARD_EN is defined.
module schmidl_cox_preamble_inserter import schmidl_cox_pkg::*; #(
  parameter int unsigned ITEM_W    = SC_ITEM_W,
  parameter int unsigned HALF_LEN  = 64,
  parameter int unsigned LEN_W     = 16,
  parameter int unsigned GUARD_LEN = 16
) (
  input  logic                        ce_clk,
  input  logic                        ce_rst_n,
  input  logic [LEN_W-1:0]            cfg_frame_len,
  input  logic                        cfg_bypass,
  input  logic                        tbl_wr_en,
  input  logic [$clog2(HALF_LEN)-1:0] tbl_wr_addr,
  input  logic [ITEM_W-1:0]           tbl_wr_data,
  input  logic [ITEM_W-1:0]           s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        s_axis_tlast,
  output logic                        s_axis_tready,
  output logic [ITEM_W-1:0]           m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  input  logic                        m_axis_tready,
  output logic                        frame_start,
  output logic                        err_short_frame
);

  localparam int unsigned AW = $clog2(HALF_LEN);
  localparam int unsigned PW = AW + 1;

  if (HALF_LEN < 2 || (HALF_LEN & (HALF_LEN - 1)) != 0) begin : g_bad_half_len
    $error("HALF_LEN must be a power of two >= 2");
  end
  if (GUARD_LEN < 1) begin : g_bad_guard_len
    $error("GUARD_LEN must be >= 1");
  end

  sc_tx_state_t      state;
  logic [PW-1:0]     pre_cnt;
  logic [LEN_W-1:0]  pay_cnt;
  logic [LEN_W-1:0]  len_q;
  logic [ITEM_W-1:0] out_data;
  logic              out_valid;
  logic              out_last;
  logic              out_first;
  logic [ITEM_W-1:0] rom_data;
  logic [AW-1:0]     rd_addr;
  logic              load_ok;
  logic              in_fire;
  logic              start;
  logic              pre_end;
  logic              at_len;

`ifdef SC_TX_GUARD_EN
  localparam int unsigned GW = $clog2(GUARD_LEN + 1);
  logic [GW-1:0] guard_cnt;
`endif

  assign load_ok         = !out_valid || m_axis_tready;
  assign s_axis_tready   = (state == PAYLOAD) && load_ok;
  assign in_fire         = s_axis_tvalid && s_axis_tready;
  assign start           = (state == IDLE) && s_axis_tvalid && (cfg_frame_len != '0);
  assign pre_end         = (pre_cnt == PW'(2 * HALF_LEN - 1));
  assign at_len          = (pay_cnt == len_q - LEN_W'(1));

  assign m_axis_tdata    = out_data;
  assign m_axis_tvalid   = out_valid;
  assign m_axis_tlast    = out_last;
  assign frame_start     = out_valid && m_axis_tready && out_first;

  // Read address runs one entry ahead whenever the output register takes a sample.
  always_comb begin
    rd_addr = pre_cnt[AW-1:0];
    if (state == PREAMBLE && load_ok) rd_addr = pre_cnt[AW-1:0] + AW'(1);
  end

  schmidl_cox_preamble_rom #(
    .ITEM_W   (ITEM_W),
    .HALF_LEN (HALF_LEN)
  ) u_rom (
    .clk     (ce_clk),
    .rst_n   (ce_rst_n),
    .wr_en   (tbl_wr_en && state == IDLE),
    .wr_addr (tbl_wr_addr),
    .wr_data (tbl_wr_data),
    .rd_addr (rd_addr),
    .rd_data (rom_data)
  );

  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      state           <= IDLE;
      pre_cnt         <= '0;
      pay_cnt         <= '0;
      len_q           <= '0;
      out_data        <= '0;
      out_valid       <= 1'b0;
      out_last        <= 1'b0;
      out_first       <= 1'b0;
      err_short_frame <= 1'b0;
`ifdef SC_TX_GUARD_EN
      guard_cnt       <= '0;
`endif
    end else begin
      err_short_frame <= 1'b0;
      if (out_valid && m_axis_tready) out_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            len_q   <= cfg_frame_len;
            pre_cnt <= '0;
            pay_cnt <= '0;
            state   <= cfg_bypass ? PAYLOAD : PREAMBLE;
          end
        end
        PREAMBLE: begin
          if (load_ok) begin
            out_data  <= rom_data;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            out_first <= (pre_cnt == '0);
            pre_cnt   <= pre_end ? '0 : pre_cnt + PW'(1);
            if (pre_end) state <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (in_fire) begin
            out_data        <= s_axis_tdata;
            out_valid       <= 1'b1;
            out_first       <= 1'b0;
            out_last        <= 1'b0;
            pay_cnt         <= pay_cnt + LEN_W'(1);
            err_short_frame <= s_axis_tlast && !at_len;
            if (at_len || s_axis_tlast) begin
              pay_cnt <= '0;
`ifdef SC_TX_GUARD_EN
              guard_cnt <= '0;
              state     <= GUARD;
`else
              out_last  <= 1'b1;
              state     <= IDLE;
`endif
            end
          end
        end
`ifdef SC_TX_GUARD_EN
        GUARD: begin
          if (load_ok) begin
            out_data  <= ITEM_W'(SC_ZERO_SAMPLE);
            out_valid <= 1'b1;
            out_first <= 1'b0;
            out_last  <= (guard_cnt == GW'(GUARD_LEN - 1));
            guard_cnt <= guard_cnt + GW'(1);
            if (guard_cnt == GW'(GUARD_LEN - 1)) state <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_schmidl_cox_preamble_inserter.sv
// Directed, table-driven bench for the Schmidl-Cox preamble inserter (HALF_LEN=4, GUARD_LEN=2).
`timescale 1ns/1ps
module tb_schmidl_cox_preamble_inserter;

  localparam int unsigned HL = 4;

  logic        ce_clk = 1'b0;
  logic        ce_rst_n = 1'b0;
  logic [15:0] cfg_frame_len = '0;
  logic        cfg_bypass = 1'b0;
  logic        tbl_wr_en = 1'b0;
  logic [1:0]  tbl_wr_addr = '0;
  logic [31:0] tbl_wr_data = '0;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready = 1'b1;
  logic        frame_start;
  logic        err_short_frame;

  schmidl_cox_preamble_inserter #(
    .ITEM_W    (32),
    .HALF_LEN  (HL),
    .LEN_W     (16),
    .GUARD_LEN (2)
  ) dut (
    .ce_clk          (ce_clk),
    .ce_rst_n        (ce_rst_n),
    .cfg_frame_len   (cfg_frame_len),
    .cfg_bypass      (cfg_bypass),
    .tbl_wr_en       (tbl_wr_en),
    .tbl_wr_addr     (tbl_wr_addr),
    .tbl_wr_data     (tbl_wr_data),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tlast    (s_axis_tlast),
    .s_axis_tready   (s_axis_tready),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tready   (m_axis_tready),
    .frame_start     (frame_start),
    .err_short_frame (err_short_frame)
  );

  always #5 ce_clk = ~ce_clk;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } smp_t;

  typedef struct packed {
    logic             bypass;
    logic [15:0]      len;
    logic             stall;
    logic [7:0]       n_in;
    logic [7:0][31:0] in_d;
    logic [7:0]       in_l;
    logic [7:0]       n_exp;
    logic [31:0][31:0] exp_d;
    logic [31:0]      exp_l;
    logic [7:0]       exp_fs;
    logic [7:0]       exp_err;
  } tc_t;

  localparam logic [31:0] A = 32'hAAAA_0001, B = 32'hBBBB_0002, C = 32'hCCCC_0003,
                          D = 32'hDDDD_0004, E = 32'hEEEE_0005, F = 32'hFFFF_0006,
                          G = 32'h7777_0007;

  tc_t  tcs [6];
  smp_t got_q [$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   fs_cnt = 0;
  int   er_cnt = 0;
  bit   stall_en = 1'b0;
  bit   hold_chk = 1'b0;
  smp_t hold_s;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic void add_in(input int t, input logic [31:0] d, input logic l);
    tcs[t].in_d[tcs[t].n_in] = d;
    tcs[t].in_l[tcs[t].n_in] = l;
    tcs[t].n_in++;
  endfunction

  function automatic void put_exp(input int t, input logic [31:0] d, input logic l);
    tcs[t].exp_d[tcs[t].n_exp] = d;
    tcs[t].exp_l[tcs[t].n_exp] = l;
    tcs[t].n_exp++;
  endfunction

  // Frame-ending sample; with the guard build the tlast moves onto two trailing zeros.
  function automatic void add_exp(input int t, input logic [31:0] d, input logic l);
`ifdef SC_TX_GUARD_EN
    if (l) begin
      put_exp(t, d, 1'b0);
      put_exp(t, 32'h0, 1'b0);
      put_exp(t, 32'h0, 1'b1);
    end else put_exp(t, d, 1'b0);
`else
    put_exp(t, d, l);
`endif
  endfunction

  function automatic void add_pre(input int t);
    for (int unsigned r = 0; r < 2; r++)
      for (int unsigned k = 0; k < HL; k++) put_exp(t, 32'(k + 1), 1'b0);
  endfunction

  // Output monitor: drives tready, records handshakes, checks hold stability during stalls.
  initial begin
    forever begin
      @(negedge ce_clk);
      m_axis_tready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      #2;
      if (ce_rst_n) begin
        if (hold_chk) begin
          check("hold_tvalid", 32'(m_axis_tvalid), 32'd1);
          check("hold_tdata", m_axis_tdata, hold_s.d);
          check("hold_tlast", 32'(m_axis_tlast), 32'(hold_s.l));
        end
        hold_chk = m_axis_tvalid && !m_axis_tready;
        hold_s   = '{d: m_axis_tdata, l: m_axis_tlast};
        if (m_axis_tvalid && m_axis_tready) got_q.push_back('{d: m_axis_tdata, l: m_axis_tlast});
        if (frame_start) fs_cnt++;
        if (err_short_frame) er_cnt++;
      end else hold_chk = 1'b0;
    end
  end

  task automatic run_case(input int t);
    int b;
    got_q.delete();
    fs_cnt = 0;
    er_cnt = 0;
    @(negedge ce_clk);
    cfg_bypass    = tcs[t].bypass;
    cfg_frame_len = tcs[t].len;
    stall_en      = tcs[t].stall;
    for (int i = 0; i < int'(tcs[t].n_in); i++) begin
      @(negedge ce_clk);
      s_axis_tdata  = tcs[t].in_d[i];
      s_axis_tlast  = tcs[t].in_l[i];
      s_axis_tvalid = 1'b1;
      #1;
      b = 0;
      while (!s_axis_tready && b < 200) begin
        @(negedge ce_clk);
        #1;
        b++;
      end
      check($sformatf("case%0d_in%0d_accept_timeout", t, i), 32'(b >= 200), 32'd0);
      if (b >= 200) break;
      @(posedge ce_clk);
    end
    @(negedge ce_clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    b = 0;
    while (got_q.size() < int'(tcs[t].n_exp) && b < 300) begin
      @(negedge ce_clk);
      b++;
    end
    repeat (12) @(negedge ce_clk);
    stall_en = 1'b0;
    check($sformatf("case%0d_out_count", t), 32'(got_q.size()), 32'(tcs[t].n_exp));
    for (int i = 0; i < int'(tcs[t].n_exp) && i < got_q.size(); i++) begin
      check($sformatf("case%0d_out%0d_data", t, i), got_q[i].d, tcs[t].exp_d[i]);
      check($sformatf("case%0d_out%0d_last", t, i), 32'(got_q[i].l), 32'(tcs[t].exp_l[i]));
    end
    check($sformatf("case%0d_frame_start", t), 32'(fs_cnt), 32'(tcs[t].exp_fs));
    check($sformatf("case%0d_err_short", t), 32'(er_cnt), 32'(tcs[t].exp_err));
  endtask

  initial begin
    int b;
    for (int t = 0; t < 6; t++) tcs[t] = '0;
    // 0: normal frame, input tlast on sample L
    tcs[0].len = 3;
    add_in(0, A, 0); add_in(0, B, 0); add_in(0, C, 1);
    add_pre(0); add_exp(0, A, 0); add_exp(0, B, 0); add_exp(0, C, 1);
    tcs[0].exp_fs = 1;
    // 1: same frame under 25% downstream stall
    tcs[1] = tcs[0];
    tcs[1].stall = 1;
    // 2: short frame then a full frame without input tlast
    tcs[2].len = 5;
    add_in(2, A, 0); add_in(2, B, 1); add_in(2, C, 0); add_in(2, D, 0);
    add_in(2, E, 0); add_in(2, F, 0); add_in(2, G, 0);
    add_pre(2); add_exp(2, A, 0); add_exp(2, B, 1);
    add_pre(2); add_exp(2, C, 0); add_exp(2, D, 0); add_exp(2, E, 0);
    add_exp(2, F, 0); add_exp(2, G, 1);
    tcs[2].exp_fs = 2; tcs[2].exp_err = 1;
    // 3: bypass, two frames of L=2
    tcs[3].bypass = 1; tcs[3].len = 2;
    add_in(3, A, 0); add_in(3, B, 0); add_in(3, C, 0); add_in(3, D, 0);
    add_exp(3, A, 0); add_exp(3, B, 1); add_exp(3, C, 0); add_exp(3, D, 1);
    // 4: minimum length L=1, tlast on the only sample
    tcs[4].len = 1;
    add_in(4, E, 1);
    add_pre(4); add_exp(4, E, 1);
    tcs[4].exp_fs = 1;
    // 5: L=3 with no input tlast at all, stalled
    tcs[5].len = 3; tcs[5].stall = 1;
    add_in(5, A, 0); add_in(5, B, 0); add_in(5, C, 0);
    add_pre(5); add_exp(5, A, 0); add_exp(5, B, 0); add_exp(5, C, 1);
    tcs[5].exp_fs = 1;

    repeat (3) @(negedge ce_clk);
    #1;
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_tdata", m_axis_tdata, 32'd0);
    check("rst_tlast", 32'(m_axis_tlast), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    check("rst_err", 32'(err_short_frame), 32'd0);
    @(negedge ce_clk);
    ce_rst_n = 1'b1;

    // Zero frame length keeps the block idle with input stalled.
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = A;
    cfg_frame_len = '0;
    repeat (5) @(negedge ce_clk);
    #1;
    check("len0_s_tready", 32'(s_axis_tready), 32'd0);
    check("len0_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    s_axis_tvalid = 1'b0;

    for (int unsigned k = 0; k < HL; k++) begin
      @(negedge ce_clk);
      tbl_wr_en   = 1'b1;
      tbl_wr_addr = 2'(k);
      tbl_wr_data = 32'(k + 1);
    end
    @(negedge ce_clk);
    tbl_wr_en = 1'b0;

    for (int t = 0; t < 6; t++) run_case(t);

    // Reset during the 6th preamble sample, then a clean frame.
    got_q.delete();
    @(negedge ce_clk);
    cfg_bypass    = 1'b0;
    cfg_frame_len = 16'd3;
    s_axis_tdata  = A;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b1;
    b = 0;
    while (got_q.size() < 5 && b < 100) begin
      @(negedge ce_clk);
      b++;
    end
    check("abort_reach_6th", 32'(got_q.size()), 32'd5);
    #1;
    ce_rst_n      = 1'b0;
    s_axis_tvalid = 1'b0;
    #1;
    check("abort_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("abort_tdata", m_axis_tdata, 32'd0);
    check("abort_tlast", 32'(m_axis_tlast), 32'd0);
    check("abort_s_tready", 32'(s_axis_tready), 32'd0);
    check("abort_err", 32'(err_short_frame), 32'd0);
    repeat (3) @(negedge ce_clk);
    #1;
    check("abort_hold_tvalid", 32'(m_axis_tvalid), 32'd0);
    @(negedge ce_clk);
    ce_rst_n = 1'b1;
    run_case(0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
